// File: rtl/scmi_irq_arbiter.sv
// Purpose: latch mailbox irq pulses into pending bits, raise one level irq, round-robin claim/complete.
// Latency: pulse at t -> irq_o at t+1; claim/complete handshakes take effect on the next cycle.
// Backpressure: claim_ready_o low while a channel is in service; pending pulses are held, repeats counted as drops.
module scmi_irq_arbiter #(
    parameter int NumChannels = 4,
    parameter int CntWidth    = 8,
    localparam int IdWidth    = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumChannels-1:0] irq_pulse_i,
    input  logic [NumChannels-1:0] enable_i,
    output logic                   irq_o,
    input  logic                   claim_valid_i,
    output logic                   claim_ready_o,
    output logic [IdWidth-1:0]     claim_id_o,
    input  logic                   complete_valid_i,
    input  logic [IdWidth-1:0]     complete_id_i,
    output logic                   active_o,
    output logic [IdWidth-1:0]     active_id_o,
    output logic                   err_o,
    output logic [CntWidth-1:0]    drop_cnt_o,
    input  logic                   drop_clr_i
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    state_e                   state_q, state_d;
    logic [NumChannels-1:0]   pending_q, pending_d;
    logic [IdWidth-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IdWidth-1:0]       active_id_q, active_id_d;
    logic [CntWidth-1:0]      drop_cnt_q, drop_cnt_d;
    logic                     err_q, err_d;

    logic [NumChannels-1:0]   eligible;
    logic [NumChannels-1:0]   claim_clr;
    logic [IdWidth-1:0]       sel_id;
    logic                     sel_found;
    logic [IdWidth:0]         cand;
    logic                     claim_fire;
    logic                     complete_fire;

    assign eligible = pending_q & enable_i;

    // Round-robin pick: first eligible channel at or above rr_ptr_q, wrapping.
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NumChannels; k++) begin
            cand = {1'b0, rr_ptr_q} + (IdWidth+1)'(k);
            if (cand >= (IdWidth+1)'(NumChannels)) begin
                cand = cand - (IdWidth+1)'(NumChannels);
            end
            if (!sel_found && eligible[cand[IdWidth-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = cand[IdWidth-1:0];
            end
        end
    end

    assign irq_o         = (state_q == ST_IDLE) && (|eligible);
    assign claim_ready_o = irq_o;
    assign claim_id_o    = sel_id;
    assign active_o      = (state_q == ST_ACTIVE);
    assign active_id_o   = active_id_q;
    assign err_o         = err_q;
    assign drop_cnt_o    = drop_cnt_q;

    assign claim_fire    = claim_valid_i && claim_ready_o;
    assign complete_fire = (state_q == ST_ACTIVE) && complete_valid_i
                           && (complete_id_i == active_id_q);

    // FSM next state, service bookkeeping and illegal-complete detection.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        active_id_d = active_id_q;
        err_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (claim_fire) begin
                    state_d     = ST_ACTIVE;
                    active_id_d = sel_id;
                end
                // A complete with nothing in service is always illegal.
                if (complete_valid_i) begin
                    err_d = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (complete_fire) begin
                    state_d     = ST_IDLE;
                    active_id_d = '0;
                    rr_ptr_d    = (active_id_q == IdWidth'(NumChannels - 1))
                                  ? '0 : active_id_q + 1'b1;
                end else if (complete_valid_i) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending latch: claim clears its bit, a same-cycle pulse re-sets it.
    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NumChannels; i++) begin
            if (claim_fire && (sel_id == IdWidth'(i))) begin
                claim_clr[i] = 1'b1;
            end
        end
        pending_d = (pending_q & ~claim_clr) | irq_pulse_i;
    end

    // Drop counter: one count per pulse landing on a bit that stays pending, saturating; clear wins.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        for (int i = 0; i < NumChannels; i++) begin
            if (irq_pulse_i[i] && pending_q[i] && !claim_clr[i] && (drop_cnt_d != CntMax)) begin
                drop_cnt_d = drop_cnt_d + 1'b1;
            end
        end
        if (drop_clr_i) begin
            drop_cnt_d = '0;
        end
    end

    // State registers; reset discards all pending and in-service state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            active_id_q <= '0;
            drop_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            active_id_q <= active_id_d;
            drop_cnt_q  <= drop_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_scmi_irq_arbiter.sv
// Purpose: directed self-checking bench for scmi_irq_arbiter (4 channels, 2-bit drop counter).
// Latency: inputs change 1ns after a rising edge; outputs sampled there too.
// Backpressure: claims only issued when the bench expects claim_ready_o high.
module tb_scmi_irq_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int IW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [N-1:0]  irq_pulse_i;
    logic [N-1:0]  enable_i;
    logic          irq_o;
    logic          claim_valid_i;
    logic          claim_ready_o;
    logic [IW-1:0] claim_id_o;
    logic          complete_valid_i;
    logic [IW-1:0] complete_id_i;
    logic          active_o;
    logic [IW-1:0] active_id_o;
    logic          err_o;
    logic [CW-1:0] drop_cnt_o;
    logic          drop_clr_i;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    scmi_irq_arbiter #(.NumChannels(N), .CntWidth(CW)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .irq_pulse_i      (irq_pulse_i),
        .enable_i         (enable_i),
        .irq_o            (irq_o),
        .claim_valid_i    (claim_valid_i),
        .claim_ready_o    (claim_ready_o),
        .claim_id_o       (claim_id_o),
        .complete_valid_i (complete_valid_i),
        .complete_id_i    (complete_id_i),
        .active_o         (active_o),
        .active_id_o      (active_id_o),
        .err_o            (err_o),
        .drop_cnt_o       (drop_cnt_o),
        .drop_clr_i       (drop_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: run still going at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq_pulse_i = m;
        step();
        irq_pulse_i = '0;
    endtask

    task automatic do_claim();
        claim_valid_i = 1'b1;
        step();
        claim_valid_i = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete_valid_i = 1'b1;
        complete_id_i    = IW'(id);
        step();
        complete_valid_i = 1'b0;
        complete_id_i    = '0;
    endtask

    // Expect claim_id = id, claim it, check service, complete it, check idle.
    task automatic serve(input string tag, input int id);
        check({tag, "_irq"}, irq_o, 1);
        check({tag, "_id"}, claim_id_o, id);
        do_claim();
        check({tag, "_act"}, active_o, 1);
        check({tag, "_aid"}, active_id_o, id);
        check({tag, "_irq_act"}, irq_o, 0);
        do_complete(id);
        check({tag, "_idle"}, active_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        rst_ni           = 1'b0;
        irq_pulse_i      = '1;
        enable_i         = '1;
        claim_valid_i    = 1'b0;
        complete_valid_i = 1'b0;
        complete_id_i    = '0;
        drop_clr_i       = 1'b0;

        // Reset held with pulses applied.
        step(); step(); step();
        check("rst_irq", irq_o, 0);
        check("rst_rdy", claim_ready_o, 0);
        check("rst_cid", claim_id_o, 0);
        check("rst_act", active_o, 0);
        check("rst_aid", active_id_o, 0);
        check("rst_err", err_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        irq_pulse_i = '0;
        rst_ni      = 1'b1;
        step(); step();
        check("post_rst_irq", irq_o, 0);

        // Single event on ch2; rr_ptr becomes 3.
        pulse(4'b0100);
        check("single_rdy", claim_ready_o, 1);
        serve("single", 2);
        // rr_ptr=3: with ch1 and ch3 pending, ch3 wins; then ch1.
        pulse(4'b1010);
        serve("rr3a", 3);
        serve("rr3b", 1);
        // rr_ptr=2 now; move it to 0 via ch3.
        pulse(4'b1000);
        serve("to0", 3);

        // Round-robin from 0 over 1011.
        pulse(4'b1011);
        serve("rr_a", 0);
        serve("rr_b", 1);
        serve("rr_c", 3);
        // rr_ptr=0; move to 2 via ch1, then 1001 -> 3 then 0.
        pulse(4'b0010);
        serve("to2", 1);
        pulse(4'b1001);
        serve("rr_d", 3);
        serve("rr_e", 0);
        check("rr_empty", irq_o, 0);

        // Masking: ch1 pending but disabled.
        enable_i = 4'b1101;
        pulse(4'b0010);
        check("mask_irq", irq_o, 0);
        check("mask_cid", claim_id_o, 0);
        step();
        check("mask_hold", irq_o, 0);
        enable_i = 4'b1111;
        step();
        serve("unmask", 1);

        // Drops: five pulses on ch0, counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            pulse(4'b0001);
            check($sformatf("drop_%0d", i), drop_cnt_o, (i > 3) ? 3 : i);
        end
        drop_clr_i = 1'b1;
        step();
        drop_clr_i = 1'b0;
        check("drop_clr", drop_cnt_o, 0);
        // One more drop, then clear wins over a same-cycle drop.
        pulse(4'b0001);
        check("drop_one", drop_cnt_o, 1);
        drop_clr_i = 1'b1;
        pulse(4'b0001);
        drop_clr_i = 1'b0;
        check("drop_clr_win", drop_cnt_o, 0);
        // Pulse on claimed channel during claim: no drop, stays pending.
        check("cl_pulse_id", claim_id_o, 0);
        claim_valid_i = 1'b1;
        irq_pulse_i   = 4'b0001;
        step();
        claim_valid_i = 1'b0;
        irq_pulse_i   = '0;
        check("cl_pulse_act", active_o, 1);
        check("cl_pulse_drop", drop_cnt_o, 0);
        do_complete(0);
        check("cl_pulse_pend", irq_o, 1);
        check("cl_pulse_cid", claim_id_o, 0);

        // Errors: wrong id while ch0 active.
        do_claim();
        check("err_pre_act", active_id_o, 0);
        do_complete(1);
        check("err_wrong", err_o, 1);
        check("err_wrong_act", active_o, 1);
        check("err_wrong_aid", active_id_o, 0);
        step();
        check("err_wrong_end", err_o, 0);
        do_complete(0);
        check("err_ok", err_o, 0);
        check("err_ok_idle", active_o, 0);
        // Complete while idle.
        do_complete(2);
        check("err_idle", err_o, 1);
        check("err_idle_act", active_o, 0);
        step();
        check("err_idle_end", err_o, 0);

        // Reset in the middle of service, with a drop and a pending bit.
        pulse(4'b0100);
        do_claim();
        pulse(4'b0010);
        pulse(4'b0010);
        check("mid_drop", drop_cnt_o, 1);
        check("mid_act", active_o, 1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_act", active_o, 0);
        check("mid_rst_aid", active_id_o, 0);
        check("mid_rst_drop", drop_cnt_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_irq", irq_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        check("mid_post_irq", irq_o, 0);
        check("mid_post_err", err_o, 0);
        check("mid_post_act", active_o, 0);
        // rr_ptr back to 0: pending 1001 picks ch0 first.
        pulse(4'b1001);
        check("mid_post_rr", claim_id_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
